// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port framebuffer RAM arbiter for video scanout and host access
//
// Purpose: shares one synchronous-read single-port RAM between a stall-free
// video scanout fetch port and a host write/read port. Fixed priority is
// video, then host write, then host read. Each read's owner is carried in a
// one-bit tag, so returned data reaches only the requester that issued it.
// Optional feature macro: FB_ARB_WFIFO_EN. When it is defined, host writes are
// queued in a WF_DEPTH-entry FIFO that drains whenever video is idle.
// Without it, a host write goes straight to the RAM in the cycle it is accepted.
//
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   vid_req, vid_addr             scanout fetch request (one word per cycle)
//   vid_data, vid_data_valid      scanout read return
//   wr_valid/wr_ready/wr_addr/wr_data   host write handshake
//   rd_valid/rd_ready/rd_addr     host read handshake
//   rd_data, rd_data_valid        host read return
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata   single-port RAM side

module fb_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int WF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_data_valid,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_data_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Grant encoding; state_q holds the previous cycle's grant.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_VID  = 2'd1;
  localparam logic [1:0] S_HWR  = 2'd2;
  localparam logic [1:0] S_HRD  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          rd_tag_q, rd_tag_d;   // 1: in-flight read belongs to host, 0: video
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] vid_hold_q, rd_hold_q;
  logic          rd_pend;

  // Write candidate for this cycle, already qualified by reset and video priority.
  logic          wr_go;
  logic [AW-1:0] wr_go_addr;
  logic [DW-1:0] wr_go_data;

`ifdef FB_ARB_WFIFO_EN
  localparam int            PW       = $clog2(WF_DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(WF_DEPTH);

  logic [AW-1:0] fifo_addr_q [WF_DEPTH];
  logic [DW-1:0] fifo_data_q [WF_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic          fifo_full, fifo_empty, push;

  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign push       = wr_valid && !fifo_full;
  assign wr_ready   = !fifo_full;
  assign wr_go      = !rst && !vid_req && !fifo_empty;
  assign wr_go_addr = fifo_addr_q[rptr_q];
  assign wr_go_data = fifo_data_q[rptr_q];
  // With an empty FIFO wr_ready is high, so a presented write is a winning write;
  // holding the read back keeps it behind every write accepted so far.
  assign rd_ready   = !vid_req && fifo_empty && !wr_valid;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= wr_addr;
      fifo_data_q[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push)  wptr_q <= wptr_q + PW'(1);
      if (wr_go) rptr_q <= rptr_q + PW'(1);
      case ({push, wr_go})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
`else
  assign wr_ready   = !vid_req;
  assign wr_go      = !rst && !vid_req && wr_valid;
  assign wr_go_addr = wr_addr;
  assign wr_go_data = wr_data;
  assign rd_ready   = !vid_req && !wr_valid;

  // The queue depth only matters when the FIFO is built; this empty block
  // marks the unsupported small-depth range.
  if (WF_DEPTH < 2) begin : g_wf_depth_unsupported
  end
`endif

  always_comb begin
    state_d = S_IDLE;
    if (!rst) begin
      if (vid_req)                    state_d = S_VID;
      else if (wr_go)                 state_d = S_HWR;
      else if (rd_valid && rd_ready)  state_d = S_HRD;
    end
  end

  // Address and write data hold their last values when nothing is granted.
  always_comb begin
    mem_en    = (state_d != S_IDLE);
    mem_we    = (state_d == S_HWR);
    mem_wdata = mem_wdata_q;
    case (state_d)
      S_VID:   mem_addr = vid_addr;
      S_HWR: begin
        mem_addr  = wr_go_addr;
        mem_wdata = wr_go_data;
      end
      S_HRD:   mem_addr = rd_addr;
      default: mem_addr = mem_addr_q;
    endcase
  end

  always_comb begin
    rd_tag_d = rd_tag_q;
    if (state_d == S_HRD)      rd_tag_d = 1'b1;
    else if (state_d == S_VID) rd_tag_d = 1'b0;
  end

  // RAM data is valid the cycle after a read grant; the tag picks the owner.
  assign rd_pend        = (state_q == S_VID) || (state_q == S_HRD);
  assign vid_data_valid = rd_pend && !rd_tag_q;
  assign rd_data_valid  = rd_pend && rd_tag_q;
  assign vid_data       = vid_data_valid ? mem_rdata : vid_hold_q;
  assign rd_data        = rd_data_valid  ? mem_rdata : rd_hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_tag_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      vid_hold_q  <= '0;
      rd_hold_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_tag_q    <= rd_tag_d;
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
      if (vid_data_valid) vid_hold_q <= mem_rdata;
      if (rd_data_valid)  rd_hold_q  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - self-checking bench for fb_arbiter with a behavioural reference model

module tb_fb_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_data_valid;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  fb_arbiter #(.AW(AW), .DW(DW), .WF_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_data_valid(vid_data_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] init_pat(input int a);
    return 8'(a * 7 + 60);
  endfunction

  // Single-port synchronous-read RAM; unwritten words read as init_pat.
  logic [7:0] ram  [0:65535];
  bit         seen [0:65535];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]  <= mem_wdata;
        seen[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= seen[mem_addr] ? ram[mem_addr] : init_pat(int'(mem_addr));
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected memory contents, pending write queue, and the
  // read returns expected on the next cycle.
  logic [7:0]  shadow [int];
  logic [23:0] m_q [$];
  bit          m_vv, m_rv;
  logic [7:0]  m_vdat, m_rdat, m_vhold, m_rhold;
  logic [15:0] m_last_addr;
  logic [7:0]  m_last_wd;

  function automatic logic [7:0] sh_rd(input logic [15:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : init_pat(int'(a));
  endfunction

  task automatic model_reset();
    m_vv = 0; m_rv = 0; m_vhold = 0; m_rhold = 0;
    m_last_addr = 0; m_last_wd = 0;
    m_q.delete();
  endtask

  task automatic step(input bit r, input bit v, input logic [15:0] va,
                      input bit wv, input logic [15:0] wa, input logic [7:0] wd,
                      input bit rv, input logic [15:0] ra);
    int          g;
    logic [15:0] ga;
    logic [7:0]  gd;
    bit          e_wrdy, e_rrdy;
    @(negedge clk);
    rst = r; vid_req = v; vid_addr = va; wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra;
    #1;
    g = 0; ga = m_last_addr; gd = m_last_wd;
`ifdef FB_ARB_WFIFO_EN
    e_wrdy = (m_q.size() < D);
    e_rrdy = !v && (m_q.size() == 0) && !wv;
`else
    e_wrdy = !v;
    e_rrdy = !v && !wv;
`endif
    if (!r) begin
      if (v) begin
        g = 1; ga = va;
`ifdef FB_ARB_WFIFO_EN
      end else if (m_q.size() != 0) begin
        g = 2; ga = m_q[0][23:8]; gd = m_q[0][7:0];
`else
      end else if (wv) begin
        g = 2; ga = wa; gd = wd;
`endif
      end else if (rv && e_rrdy) begin
        g = 3; ga = ra;
      end
    end
    check_eq("wr_ready", wr_ready, e_wrdy);
    check_eq("rd_ready", rd_ready, e_rrdy);
    check_eq("mem_en", mem_en, g != 0);
    check_eq("mem_we", mem_we, g == 2);
    check_eq("mem_addr", mem_addr, ga);
    if (g == 2) check_eq("mem_wdata", mem_wdata, gd);
    check_eq("vid_data_valid", vid_data_valid, m_vv);
    check_eq("vid_data", vid_data, m_vv ? m_vdat : m_vhold);
    check_eq("rd_data_valid", rd_data_valid, m_rv);
    check_eq("rd_data", rd_data, m_rv ? m_rdat : m_rhold);
    if (m_vv) m_vhold = m_vdat;
    if (m_rv) m_rhold = m_rdat;
    m_vv = (g == 1); m_vdat = sh_rd(va);
    m_rv = (g == 3); m_rdat = sh_rd(ra);
    if (g == 2) begin
      shadow[int'(ga)] = gd;
      m_last_wd = gd;
`ifdef FB_ARB_WFIFO_EN
      void'(m_q.pop_front());
`endif
    end
    if (g != 0) m_last_addr = ga;
`ifdef FB_ARB_WFIFO_EN
    if (!r && wv && e_wrdy) m_q.push_back({wa, wd});
`endif
    if (r) model_reset();
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 0, 16'h0, 8'h0, 0, 16'h0);
  endtask

  initial begin
    rst = 1; vid_req = 0; vid_addr = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
    rd_valid = 0; rd_addr = 0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset then idle
    idle();
    check_eq("rst_wr_ready", wr_ready, 1);
    check_eq("rst_rd_ready", rd_ready, 1);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_vid_valid", vid_data_valid, 0);
    check_eq("rst_rd_valid", rd_data_valid, 0);
    check_eq("rst_vid_data", vid_data, 0);
    check_eq("rst_rd_data", rd_data, 0);

    // Write then read back
    step(0, 0, 16'h0, 1, 16'h0005, 8'h12, 0, 16'h0);
    idle();
    step(0, 0, 16'h0, 0, 16'h0, 8'h0, 1, 16'h0005);
    idle();
    check_eq("rw_rd_valid", rd_data_valid, 1);
    check_eq("rw_rd_data", rd_data, 8'h12);

    // Alternating video and host reads
    for (int i = 0; i < 8; i++)
      step(0, (i % 2) == 0, 16'h0020 + 16'(i), 0, 16'h0, 8'h0, (i % 2) == 1, 16'h0030 + 16'(i));
    idle();

    // Reset with a host read in flight
    step(0, 0, 16'h0, 0, 16'h0, 8'h0, 1, 16'h0005);
    step(1, 0, 16'h0, 0, 16'h0, 8'h0, 0, 16'h0);
    idle();
    check_eq("rst_inflight_rd_valid", rd_data_valid, 0);

`ifdef FB_ARB_WFIFO_EN
    begin
      int wi;
      int we_cnt;
      wi = 0; we_cnt = 0;
      // Six writes offered while video holds the RAM for ten cycles
      for (int c = 0; c < 10; c++) begin
        bit acc;
        acc = (wi < 6) && (m_q.size() < D);
        step(0, 1, 16'h0100 + 16'(c), wi < 6, 16'h0050 + 16'(wi), 8'hC0 + 8'(wi), 0, 16'h0);
        if (acc) wi++;
        if (c == 5) check_eq("vid_hold_wr_ready", wr_ready, 0);
      end
      for (int c = 0; c < 4; c++) begin
        idle();
        if (mem_we) we_cnt++;
      end
      check_eq("drain_we_cycles", we_cnt, 4);
      check_eq("drain_done_wr_ready", wr_ready, 1);
      while (wi < 6) begin
        step(0, 0, 16'h0, 1, 16'h0050 + 16'(wi), 8'hC0 + 8'(wi), 0, 16'h0);
        wi++;
      end
      repeat (3) idle();
    end

    // Queued write with a read of the same address pending
    step(0, 1, 16'h0200, 1, 16'h0010, 8'hAA, 1, 16'h0010);
    step(0, 0, 16'h0, 0, 16'h0, 8'h0, 1, 16'h0010);
    check_eq("raw_rd_blocked", rd_ready, 0);
    step(0, 0, 16'h0, 0, 16'h0, 8'h0, 1, 16'h0010);
    check_eq("raw_rd_accept", rd_ready, 1);
    idle();
    check_eq("raw_rd_valid", rd_data_valid, 1);
    check_eq("raw_rd_data", rd_data, 8'hAA);

    // Reset with three queued writes and a video read in flight
    for (int i = 0; i < 3; i++)
      step(0, 1, 16'h0300 + 16'(i), 1, 16'h0040 + 16'(i), 8'h90 + 8'(i), 0, 16'h0);
    step(0, 1, 16'h0303, 0, 16'h0, 8'h0, 0, 16'h0);
    step(1, 1, 16'h0304, 0, 16'h0, 8'h0, 0, 16'h0);
    idle();
    check_eq("rstq_vid_valid", vid_data_valid, 0);
    check_eq("rstq_rd_valid", rd_data_valid, 0);
    check_eq("rstq_rd_ready", rd_ready, 1);
    repeat (3) idle();
    for (int i = 0; i < 3; i++)
      check_eq("rstq_unwritten", seen[16'h0040 + 16'(i)], 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 4, 16'($urandom_range(0, 31)),
           $urandom_range(0, 9) < 4, 16'($urandom_range(0, 31)), 8'($urandom),
           $urandom_range(0, 9) < 4, 16'($urandom_range(0, 31)));
    end
    repeat (D + 2) idle();

    for (int a = 0; a < 128; a++)
      check_eq("ram_contents", seen[a] ? ram[a] : init_pat(a), sh_rd(16'(a)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
